endme_mc_core: RTL and testbench

Parametrised multi-cycle successor to the single-cycle EnDMe accumulator core. It runs the same 9-bit accumulator ISA from external instruction and data memories over req/ack handshakes, so memories may insert wait states. It adds a HALT state, a retired-instruction counter, and configurable data width and register count. It is the processor instance at the top of the EnDMe design.

---
 rtl/endme_mc_core_pkg.sv | 51 +++++
 rtl/endme_mc_core_regfile.sv | 37 +++
 rtl/endme_mc_core.sv | 156 +++++++++++++++
 tb/tb_endme_mc_core.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/endme_mc_core_pkg.sv
// Shared types for the multi-cycle EnDMe accumulator core: opcodes,
// FSM states and the 9-bit instruction decode.
package endme_mc_core_pkg;

   // ir[8] value that selects the load-immediate form
   localparam logic TYP_LDI = 1'b1;

   typedef enum logic [3:0] {
      OP_MOVA  = 4'h0,
      OP_MOVR  = 4'h1,
      OP_LDM   = 4'h2,
      OP_STM   = 4'h3,
      OP_ADD   = 4'h4,
      OP_SUB   = 4'h5,
      OP_AND   = 4'h6,
      OP_OR    = 4'h7,
      OP_XOR   = 4'h8,
      OP_SHL   = 4'h9,
      OP_SHR   = 4'hA,
      OP_BEQ   = 4'hB,
      OP_JMP   = 4'hC,
      OP_NOP_D = 4'hD,
      OP_NOP_E = 4'hE,
      OP_HALT  = 4'hF
   } opcode_e;

   typedef enum logic [1:0] {
      ST_FETCH,
      ST_EXEC,
      ST_MEM,
      ST_HALTED
   } core_state_e;

   // Decoded view of an instruction word; op/r and imm overlap in ir[7:0]
   typedef struct packed {
      logic       typ;
      opcode_e    op;
      logic [3:0] r;
      logic [7:0] imm;
   } instr_t;

   function automatic instr_t decode(input logic [8:0] ir);
      instr_t d;
      d.typ = ir[8];
      d.op  = opcode_e'(ir[7:4]);
      d.r   = ir[3:0];
      d.imm = ir[7:0];
      return d;
   endfunction

endpackage

// File: rtl/endme_mc_core_regfile.sv
// Register file: one write port, one combinational read port, indexed by
// a 4-bit field. Indices at or beyond NREG read as zero and ignore writes.
module endme_regfile #(
   parameter int DATA_W = 8,
   parameter int NREG   = 16
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              we,
   input  logic [3:0]        waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [3:0]        raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [NREG-1:0][DATA_W-1:0] regs;

   // Write port; an out-of-range index matches no entry, so it is dropped
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         regs <= '0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            if (we && (waddr == 4'(i))) regs[i] <= wdata;
         end
      end
   end

   // Read port; out-of-range index falls through to the zero default
   always_comb begin
      rdata = '0;
      for (int i = 0; i < NREG; i++) begin
         if (raddr == 4'(i)) rdata = regs[i];
      end
   end

endmodule

// File: rtl/endme_mc_core.sv
// Multi-cycle EnDMe accumulator core. Fetches 9-bit instructions and
// accesses data memory over req/ack handshakes, so either memory may add
// wait states. FETCH -> EXEC -> (MEM) -> FETCH, with a terminal HALTED.
module endme_mc_core
   import endme_mc_core_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int NREG   = 16,
   parameter int PC_W   = 16,
   parameter int CNT_W  = 32
) (
   input  logic              CLK,
   input  logic              RESET_N,
   output logic              imem_req,
   output logic [PC_W-1:0]   imem_addr,
   input  logic              imem_ack,
   input  logic [8:0]        imem_rdata,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [DATA_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic              dmem_ack,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic              halted,
   output logic [DATA_W-1:0] acc_out,
   output logic [CNT_W-1:0]  retired
);

   core_state_e        state;
   logic [PC_W-1:0]    pc;
   logic [DATA_W-1:0]  acc;
   logic [8:0]         ir;
   logic [CNT_W-1:0]   cnt;

   instr_t             d;
   logic [DATA_W-1:0]  rf_rd;
   logic               rf_we;
   logic [PC_W-1:0]    tgt;
   logic [PC_W-1:0]    pc_inc;
   logic [DATA_W-1:0]  acc_nxt;
   logic [PC_W-1:0]    pc_nxt;
   logic               is_mem;
   logic               is_halt;

   assign d       = decode(ir);
   assign tgt     = PC_W'(rf_rd);
   assign pc_inc  = pc + PC_W'(1);
   assign is_mem  = (d.typ != TYP_LDI) && ((d.op == OP_LDM) || (d.op == OP_STM));
   assign is_halt = (d.typ != TYP_LDI) && (d.op == OP_HALT);

   // MOVR writes on the EXEC commit edge so the next instruction sees it
   assign rf_we   = (state == ST_EXEC) && (d.typ != TYP_LDI) && (d.op == OP_MOVR);

   endme_regfile #(
      .DATA_W (DATA_W),
      .NREG   (NREG)
   ) u_rf (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .we      (rf_we),
      .waddr   (d.r),
      .wdata   (acc),
      .raddr   (d.r),
      .rdata   (rf_rd)
   );

   // ALU and next-pc for register/branch instructions committed in EXEC
   always_comb begin
      acc_nxt = acc;
      pc_nxt  = pc_inc;
      if (d.typ == TYP_LDI) begin
         acc_nxt = DATA_W'(d.imm);
      end else begin
         unique case (d.op)
            OP_MOVA: acc_nxt = rf_rd;
            OP_ADD:  acc_nxt = acc + rf_rd;
            OP_SUB:  acc_nxt = acc - rf_rd;
            OP_AND:  acc_nxt = acc & rf_rd;
            OP_OR:   acc_nxt = acc | rf_rd;
            OP_XOR:  acc_nxt = acc ^ rf_rd;
            OP_SHL:  acc_nxt = acc << 1;
            OP_SHR:  acc_nxt = acc >> 1;
            OP_BEQ:  if (acc == DATA_W'(1)) pc_nxt = tgt;
            OP_JMP:  pc_nxt = tgt;
            default: ;
         endcase
      end
   end

   // Core FSM; requests are registered and reset low immediately
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state      <= ST_FETCH;
         pc         <= '0;
         acc        <= '0;
         ir         <= '0;
         cnt        <= '0;
         imem_req   <= 1'b0;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         halted     <= 1'b0;
      end else begin
         unique case (state)
            ST_FETCH: begin
               // req low only in the first cycle out of reset
               if (!imem_req) begin
                  imem_req <= 1'b1;
               end else if (imem_ack) begin
                  ir       <= imem_rdata;
                  imem_req <= 1'b0;
                  state    <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (is_mem) begin
                  dmem_req   <= 1'b1;
                  dmem_we    <= (d.op == OP_STM);
                  dmem_addr  <= rf_rd;
                  dmem_wdata <= acc;
                  state      <= ST_MEM;
               end else if (is_halt) begin
                  halted <= 1'b1;
                  cnt    <= cnt + CNT_W'(1);
                  state  <= ST_HALTED;
               end else begin
                  acc      <= acc_nxt;
                  pc       <= pc_nxt;
                  cnt      <= cnt + CNT_W'(1);
                  imem_req <= 1'b1;
                  state    <= ST_FETCH;
               end
            end
            ST_MEM: begin
               if (dmem_ack) begin
                  if (!dmem_we) acc <= dmem_rdata;
                  dmem_req <= 1'b0;
                  dmem_we  <= 1'b0;
                  pc       <= pc_inc;
                  cnt      <= cnt + CNT_W'(1);
                  imem_req <= 1'b1;
                  state    <= ST_FETCH;
               end
            end
            ST_HALTED: ;
            default: state <= ST_FETCH;
         endcase
      end
   end

   assign imem_addr = pc;
   assign acc_out   = acc;
   assign retired   = cnt;

endmodule

// File: tb/tb_endme_mc_core.sv
// Directed bench for endme_mc_core: fetch-address and data-access
// scoreboards fed by the stimulus, plus directed architectural checks.
module tb_endme_mc_core;

   typedef struct packed {
      logic       we;
      logic [7:0] addr;
      logic [7:0] wd;
   } dacc_t;

   logic CLK = 1'b0;
   logic rst_n = 1'b0;
   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int nchk = 0;
   int nerr = 0;

   // ---------------- DUT0: default parameters, wait-state memories
   logic        imem_req0, imem_ack0, dmem_req0, dmem_we0, dmem_ack0, halted0;
   logic [15:0] imem_addr0;
   logic [8:0]  imem_rdata0;
   logic [7:0]  dmem_addr0, dmem_wdata0, dmem_rdata0, acc0;
   logic [31:0] retired0;

   endme_mc_core u_dut0 (
      .CLK(CLK), .RESET_N(rst_n),
      .imem_req(imem_req0), .imem_addr(imem_addr0), .imem_ack(imem_ack0), .imem_rdata(imem_rdata0),
      .dmem_req(dmem_req0), .dmem_we(dmem_we0), .dmem_addr(dmem_addr0), .dmem_wdata(dmem_wdata0),
      .dmem_ack(dmem_ack0), .dmem_rdata(dmem_rdata0),
      .halted(halted0), .acc_out(acc0), .retired(retired0)
   );

   logic [8:0] imem0 [0:255];
   logic [7:0] dmem0 [0:255];
   int iwait = 0, dwait = 0, icnt = 0, dcnt = 0, st_cnt = 0;

   always @(posedge CLK) begin
      icnt <= (imem_req0 && !imem_ack0) ? icnt + 1 : 0;
      dcnt <= (dmem_req0 && !dmem_ack0) ? dcnt + 1 : 0;
   end
   assign imem_ack0   = imem_req0 && (icnt >= iwait);
   assign dmem_ack0   = dmem_req0 && (dcnt >= dwait);
   assign imem_rdata0 = imem0[imem_addr0[7:0]];
   assign dmem_rdata0 = dmem0[dmem_addr0];

   always @(posedge CLK) begin
      if (dmem_req0 && dmem_ack0 && dmem_we0) begin
         dmem0[dmem_addr0] <= dmem_wdata0;
         st_cnt <= st_cnt + 1;
      end
   end

   // ---------------- DUT1: DATA_W=16, NREG=4, zero-wait memories
   logic        imem_req1, dmem_req1, dmem_we1, halted1;
   logic [15:0] imem_addr1, dmem_addr1, dmem_wdata1, acc1;
   logic [8:0]  imem_rdata1;
   logic [31:0] retired1;
   logic [8:0]  imem1 [0:65535];

   assign imem_rdata1 = imem1[imem_addr1];

   endme_mc_core #(.DATA_W(16), .NREG(4), .PC_W(16), .CNT_W(32)) u_dut1 (
      .CLK(CLK), .RESET_N(rst_n),
      .imem_req(imem_req1), .imem_addr(imem_addr1), .imem_ack(imem_req1), .imem_rdata(imem_rdata1),
      .dmem_req(dmem_req1), .dmem_we(dmem_we1), .dmem_addr(dmem_addr1), .dmem_wdata(dmem_wdata1),
      .dmem_ack(dmem_req1), .dmem_rdata(16'h0000),
      .halted(halted1), .acc_out(acc1), .retired(retired1)
   );

   // ---------------- scoreboards
   logic [15:0] exp0[$];
   logic [15:0] exp1[$];
   dacc_t       dexp[$];
   int          ftimes[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   logic        ipend = 1'b0, dpend = 1'b0;
   logic [15:0] ihold;
   dacc_t       dhold, dcur;

   // Sample away from the active edge: handshake stability and scoreboards
   always @(negedge CLK) begin
      if (!rst_n) begin
         ipend = 1'b0;
         dpend = 1'b0;
      end else begin
         if (imem_req0) begin
            if (ipend) chk("imem_addr_hold", imem_addr0, ihold);
            ipend = !imem_ack0;
            ihold = imem_addr0;
            if (imem_ack0) begin
               ftimes.push_back(cyc);
               if (exp0.size() > 0) chk("fetch_addr0", imem_addr0, exp0.pop_front());
            end
         end else begin
            ipend = 1'b0;
         end
         dcur = '{we: dmem_we0, addr: dmem_addr0, wd: dmem_wdata0};
         if (dmem_req0) begin
            if (dpend) chk("dmem_hold", dcur, dhold);
            dpend = !dmem_ack0;
            dhold = dcur;
            if (dmem_ack0 && dexp.size() > 0) begin
               dacc_t e;
               e = dexp.pop_front();
               chk("dmem_we", dcur.we, e.we);
               chk("dmem_addr", dcur.addr, e.addr);
               if (e.we) chk("dmem_wdata", dcur.wd, e.wd);
            end
         end else begin
            dpend = 1'b0;
         end
         if (imem_req1 && exp1.size() > 0) chk("fetch_addr1", imem_addr1, exp1.pop_front());
      end
   end

   // ---------------- programs
   localparam logic [8:0] P_BASIC [5]  = '{9'h105, 9'h012, 9'h103, 9'h042, 9'h0F0};
   localparam logic [8:0] P_MEM   [7]  = '{9'h140, 9'h011, 9'h1A5, 9'h031, 9'h100, 9'h021, 9'h0F0};
   localparam logic [8:0] P_ALU   [10] = '{9'h1F0, 9'h015, 9'h13C, 9'h065, 9'h085,
                                          9'h0A0, 9'h075, 9'h0D0, 9'h090, 9'h0F0};
   localparam logic [8:0] P_ABORT [5]  = '{9'h140, 9'h011, 9'h177, 9'h031, 9'h0F0};
   localparam logic [8:0] P_WRAP  [6]  = '{9'h101, 9'h011, 9'h100, 9'h051, 9'h041, 9'h0F0};
   localparam logic [8:0] P_OOR   [5]  = '{9'h155, 9'h017, 9'h133, 9'h007, 9'h0F0};
   localparam logic [8:0] P_JMP   [6]  = '{9'h101, 9'h011, 9'h100, 9'h051, 9'h012, 9'h0C2};

   task automatic hold_reset();
      rst_n = 1'b0;
      @(negedge CLK);
      ftimes.delete();
      exp0.delete();
      exp1.delete();
      dexp.delete();
      for (int i = 0; i < 256; i++) imem0[i] = 9'h0F0;
   endtask

   task automatic release_reset();
      @(negedge CLK);
      rst_n = 1'b1;
   endtask

   task automatic wait_halt(input bit d);
      int n = 0;
      while (!(d ? halted1 : halted0) && n < 300) begin
         @(negedge CLK);
         n++;
      end
      chk(d ? "halt_reached1" : "halt_reached0", d ? halted1 : halted0, 1'b1);
   endtask

   task automatic chk_lat(input int idx, input int lat);
      chk($sformatf("latency_%0d", idx), ftimes[idx+1] - ftimes[idx], lat);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 65536; i++) imem1[i] = 9'h0F0;

      // ---- T1: reset state and zero-wait basic program
      hold_reset();
      for (int i = 0; i < 5; i++) imem0[i] = P_BASIC[i];
      for (int i = 0; i < 5; i++) exp0.push_back(16'(i));
      #1;
      chk("rst_imem_req", imem_req0, 1'b0);
      chk("rst_dmem_req", dmem_req0, 1'b0);
      chk("rst_dmem_we", dmem_we0, 1'b0);
      chk("rst_halted", halted0, 1'b0);
      chk("rst_acc", acc0, 8'h00);
      chk("rst_retired", retired0, 32'd0);
      chk("rst_imem_addr", imem_addr0, 16'h0000);
      chk("rst_dmem_addr", {dmem_addr0, dmem_wdata0}, 16'h0000);
      release_reset();
      @(posedge CLK); #1;
      chk("first_req", imem_req0, 1'b1);
      wait_halt(0);
      chk("t1_acc", acc0, 8'd8);
      chk("t1_retired", retired0, 32'd5);
      chk("t1_pc", imem_addr0, 16'd4);
      chk("t1_no_req", {imem_req0, dmem_req0}, 2'b00);
      chk("t1_fetches", ftimes.size(), 5);
      for (int i = 0; i < 4; i++) chk_lat(i, 2);
      chk("t1_sb_empty", exp0.size(), 0);

      // ---- T2: three wait states on every fetch
      hold_reset();
      iwait = 3;
      for (int i = 0; i < 5; i++) imem0[i] = P_BASIC[i];
      for (int i = 0; i < 5; i++) exp0.push_back(16'(i));
      release_reset();
      wait_halt(0);
      chk("t2_acc", acc0, 8'd8);
      for (int i = 0; i < 4; i++) chk_lat(i, 5);
      chk("t2_sb_empty", exp0.size(), 0);
      iwait = 0;

      // ---- T3: store then load at 0x40 with two data wait states
      hold_reset();
      dwait = 2;
      for (int i = 0; i < 7; i++) imem0[i] = P_MEM[i];
      for (int i = 0; i < 7; i++) exp0.push_back(16'(i));
      dexp.push_back('{we: 1'b1, addr: 8'h40, wd: 8'hA5});
      dexp.push_back('{we: 1'b0, addr: 8'h40, wd: 8'h00});
      release_reset();
      wait_halt(0);
      chk("t3_acc_loaded", acc0, 8'hA5);
      chk("t3_mem", dmem0[8'h40], 8'hA5);
      chk("t3_retired", retired0, 32'd7);
      chk_lat(3, 5);
      chk_lat(5, 5);
      chk("t3_dsb_empty", dexp.size(), 0);
      dwait = 0;

      // ---- T4: BEQ taken (acc=1) then not taken (acc=2)
      hold_reset();
      imem0[0] = 9'h110; imem0[1] = 9'h013; imem0[2] = 9'h101; imem0[3] = 9'h0B3;
      imem0[16] = 9'h102; imem0[17] = 9'h0B3; imem0[18] = 9'h0F0;
      for (int i = 0; i < 4; i++) exp0.push_back(16'(i));
      exp0.push_back(16'h10); exp0.push_back(16'h11); exp0.push_back(16'h12);
      release_reset();
      wait_halt(0);
      chk("t4_acc", acc0, 8'd2);
      chk("t4_pc", imem_addr0, 16'h12);
      chk("t4_retired", retired0, 32'd7);
      chk("t4_sb_empty", exp0.size(), 0);

      // ---- T5: logic/shift chain with NOP
      hold_reset();
      for (int i = 0; i < 10; i++) imem0[i] = P_ALU[i];
      release_reset();
      wait_halt(0);
      chk("t5_acc", acc0, 8'hE0);
      chk("t5_retired", retired0, 32'd10);

      // ---- T6: reset pulsed during a pending store
      hold_reset();
      dwait = 30;
      for (int i = 0; i < 5; i++) imem0[i] = P_ABORT[i];
      release_reset();
      begin
         int n = 0;
         while (!dmem_req0 && n < 50) begin
            @(negedge CLK);
            n++;
         end
      end
      chk("t6_store_pending", {dmem_req0, dmem_we0}, 2'b11);
      begin
         int sc;
         sc = st_cnt;
         @(negedge CLK); #2;
         rst_n = 1'b0;
         #1;
         chk("t6_dmem_req_drop", dmem_req0, 1'b0);
         chk("t6_retired_clr", retired0, 32'd0);
         @(negedge CLK);
         chk("t6_no_store", st_cnt, sc);
         chk("t6_mem_kept", dmem0[8'h40], 8'hA5);
      end
      dwait = 0;
      ftimes.delete();
      for (int i = 0; i < 5; i++) exp0.push_back(16'(i));
      dexp.push_back('{we: 1'b1, addr: 8'h40, wd: 8'h77});
      release_reset();
      @(posedge CLK); #1;
      chk("t6_restart_addr", imem_addr0, 16'h0000);
      chk("t6_restart_retired", retired0, 32'd0);
      wait_halt(0);
      chk("t6_retired", retired0, 32'd5);
      chk("t6_mem", dmem0[8'h40], 8'h77);
      chk("t6_sb_empty", exp0.size() + dexp.size(), 0);

      // ---- T7: DATA_W=16 wrap-around ADD
      hold_reset();
      for (int i = 0; i < 6; i++) imem1[i] = P_WRAP[i];
      release_reset();
      wait_halt(1);
      chk("t7_add_wrap", acc1, 16'h0000);
      chk("t7_retired", retired1, 32'd6);

      // ---- T8: NREG=4, r=7 write dropped and read as zero
      hold_reset();
      for (int i = 0; i < 5; i++) imem1[i] = P_OOR[i];
      release_reset();
      wait_halt(1);
      chk("t8_oor_read", acc1, 16'h0000);
      chk("t8_retired", retired1, 32'd5);

      // ---- T9: JMP to 0xFFFF, NOP there wraps pc to 0
      hold_reset();
      for (int i = 0; i < 6; i++) imem1[i] = P_JMP[i];
      imem1[6] = 9'h0F0;
      imem1[16'hFFFF] = 9'h0D0;
      for (int i = 0; i < 6; i++) exp1.push_back(16'(i));
      exp1.push_back(16'hFFFF);
      exp1.push_back(16'h0000);
      release_reset();
      begin
         int n = 0;
         while (exp1.size() > 0 && n < 100) begin
            @(negedge CLK);
            n++;
         end
      end
      chk("t9_sb_empty", exp1.size(), 0);
      chk("t9_retired", retired1, 32'd7);

      rst_n = 1'b0;
      @(negedge CLK);
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
